// File: rtl/core_sequencer_pkg.sv
// Shared definitions for the RV32IM multicycle sequencer: state encoding and
// the default performance-counter width.
package core_sequencer_pkg;

    typedef enum logic [2:0] {
        FETCH      = 3'd0,
        DECODE     = 3'd1,
        EXEC       = 3'd2,
        MEM        = 3'd3,
        WRITE      = 3'd4,
        FETCH_WAIT = 3'd5,
        MEM_WAIT   = 3'd6,
        TRAP       = 3'd7
    } state_t;

    localparam int CNT_W_DEF = 32;

endpackage

// File: rtl/core_sequencer_perf_counters.sv
// Cycle and retired-instruction counters with synchronous clear; both wrap
// from all-ones to zero.
module perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             cyc_inc,
    input  logic             ret_inc,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cycle_cnt_r;
    logic [CNT_W-1:0] instret_cnt_r;

    // Counter registers
    always_ff @(posedge clk) begin
        if (clr) begin
            cycle_cnt_r   <= {CNT_W{1'b0}};
            instret_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (cyc_inc) begin
                cycle_cnt_r <= cycle_cnt_r + CNT_ONE;
            end else begin
                cycle_cnt_r <= cycle_cnt_r;
            end
            if (ret_inc) begin
                instret_cnt_r <= instret_cnt_r + CNT_ONE;
            end else begin
                instret_cnt_r <= instret_cnt_r;
            end
        end
    end

    assign cycle_cnt   = cycle_cnt_r;
    assign instret_cnt = instret_cnt_r;

endmodule

// File: rtl/core_sequencer.sv
// Multicycle fetch/decode/execute/memory/writeback control FSM for the RV32IM core.
// Optional performance counters are built when CORE_PERF_COUNTER_EN is defined.
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    output logic [2:0]       state,
    output logic             imem_req,
    input  logic             imem_ready,
    input  logic             imem_valid,
    output logic             ir_we,
    input  logic             illegal,
    input  logic             is_load,
    input  logic             is_store,
    input  logic             is_muldiv,
    input  logic             writes_rd,
    output logic             alu_start,
    input  logic             alu_done,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ready,
    input  logic             dmem_valid,
    output logic             rf_we,
    output logic             pc_we,
    output logic             trapped,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    state_t state_r;
    state_t next_state_s;
    logic   exec_first_r;
    logic   imem_req_s, ir_we_s, alu_start_s, dmem_req_s, dmem_we_s;
    logic   rf_we_s, pc_we_s, trapped_s;

    // State register and first-EXEC-cycle flag for the single mul/div start pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= FETCH;
            exec_first_r <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            exec_first_r <= (state_r != EXEC) && (next_state_s == EXEC);
        end
    end

    // Next-state and ungated strobe decode
    always_comb begin
        next_state_s = state_r;
        imem_req_s   = 1'b0;
        ir_we_s      = 1'b0;
        alu_start_s  = 1'b0;
        dmem_req_s   = 1'b0;
        dmem_we_s    = 1'b0;
        rf_we_s      = 1'b0;
        pc_we_s      = 1'b0;
        trapped_s    = 1'b0;
        case (state_r)
            FETCH: begin
                imem_req_s = 1'b1;
                if (imem_ready && imem_valid) begin
                    ir_we_s      = 1'b1;
                    next_state_s = DECODE;
                end else if (imem_ready) begin
                    next_state_s = FETCH_WAIT;
                end else begin
                    next_state_s = FETCH;
                end
            end
            FETCH_WAIT: begin
                if (imem_valid) begin
                    ir_we_s      = 1'b1;
                    next_state_s = DECODE;
                end else begin
                    next_state_s = FETCH_WAIT;
                end
            end
            DECODE: begin
                next_state_s = EXEC;
            end
            EXEC: begin
                if (illegal) begin
                    next_state_s = TRAP;
                end else if (is_muldiv) begin
                    alu_start_s  = exec_first_r;
                    next_state_s = alu_done ? WRITE : EXEC;
                end else if (is_load || is_store) begin
                    next_state_s = MEM;
                end else begin
                    next_state_s = WRITE;
                end
            end
            MEM: begin
                dmem_req_s = 1'b1;
                dmem_we_s  = is_store;
                if (dmem_ready && dmem_valid) begin
                    next_state_s = WRITE;
                end else if (dmem_ready) begin
                    next_state_s = MEM_WAIT;
                end else begin
                    next_state_s = MEM;
                end
            end
            MEM_WAIT: begin
                next_state_s = dmem_valid ? WRITE : MEM_WAIT;
            end
            WRITE: begin
                rf_we_s      = writes_rd;
                pc_we_s      = 1'b1;
                next_state_s = FETCH;
            end
            TRAP: begin
                trapped_s    = 1'b1;
                next_state_s = TRAP;
            end
            default: begin
                next_state_s = FETCH;
            end
        endcase
    end

    // Reset suppresses every strobe within the reset cycle itself
    assign state     = state_r;
    assign imem_req  = imem_req_s  & ~rst;
    assign ir_we     = ir_we_s     & ~rst;
    assign alu_start = alu_start_s & ~rst;
    assign dmem_req  = dmem_req_s  & ~rst;
    assign dmem_we   = dmem_we_s   & ~rst;
    assign rf_we     = rf_we_s     & ~rst;
    assign pc_we     = pc_we_s     & ~rst;
    assign trapped   = trapped_s   & ~rst;

`ifdef CORE_PERF_COUNTER_EN
    perf_counters #(
        .CNT_W(CNT_W)
    ) u_perf_counters (
        .clk         (clk),
        .clr         (rst),
        .cyc_inc     (state_r != TRAP),
        .ret_inc     (state_r == WRITE),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );
`else
    assign cycle_cnt   = {CNT_W{1'b0}};
    assign instret_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Randomized bench for core_sequencer: builds a per-cycle expected trace from
// instruction-level timing (handshake latencies) and checks the DUT against it.
module tb_core_sequencer;

    localparam int CNT_W = 32;

    localparam logic [7:0] O_IREQ = 8'b1000_0000;
    localparam logic [7:0] O_IRWE = 8'b0100_0000;
    localparam logic [7:0] O_AST  = 8'b0010_0000;
    localparam logic [7:0] O_DREQ = 8'b0001_0000;
    localparam logic [7:0] O_DWE  = 8'b0000_1000;
    localparam logic [7:0] O_RFWE = 8'b0000_0100;
    localparam logic [7:0] O_PCWE = 8'b0000_0010;
    localparam logic [7:0] O_TRAP = 8'b0000_0001;

    logic clk = 1'b0;
    logic rst, imem_ready, imem_valid, illegal, is_load, is_store, is_muldiv;
    logic writes_rd, alu_done, dmem_ready, dmem_valid;
    logic [2:0] state;
    logic imem_req, ir_we, alu_start, dmem_req, dmem_we, rf_we, pc_we, trapped;
    logic [CNT_W-1:0] cycle_cnt, instret_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst, ir, iv, dr, dv, ad, ill, ld, st, md, wr;
        logic [2:0] est;
        logic [7:0] eout;
    } cyc_t;

    cyc_t q[$];

    core_sequencer #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .state(state),
        .imem_req(imem_req), .imem_ready(imem_ready), .imem_valid(imem_valid),
        .ir_we(ir_we), .illegal(illegal), .is_load(is_load), .is_store(is_store),
        .is_muldiv(is_muldiv), .writes_rd(writes_rd), .alu_start(alu_start),
        .alu_done(alu_done), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_ready(dmem_ready), .dmem_valid(dmem_valid), .rf_we(rf_we),
        .pc_we(pc_we), .trapped(trapped), .cycle_cnt(cycle_cnt),
        .instret_cnt(instret_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Irrelevant inputs are randomized to show they are ignored
    function automatic cyc_t noise();
        cyc_t c;
        c.rst = 1'b0;
        c.ir  = 1'($urandom_range(0, 1));
        c.iv  = 1'($urandom_range(0, 1));
        c.dr  = 1'($urandom_range(0, 1));
        c.dv  = 1'($urandom_range(0, 1));
        c.ad  = 1'($urandom_range(0, 1));
        c.ill = 1'($urandom_range(0, 1));
        c.ld  = 1'($urandom_range(0, 1));
        c.st  = 1'($urandom_range(0, 1));
        c.md  = 1'($urandom_range(0, 1));
        c.wr  = 1'($urandom_range(0, 1));
        c.est  = 3'd0;
        c.eout = 8'd0;
        return c;
    endfunction

    function automatic cyc_t decoded(input cyc_t ci, input bit ld, input bit st, input bit md);
        cyc_t c;
        c = ci;
        c.ill = 1'b0;
        c.ld  = ld;
        c.st  = st;
        c.md  = md;
        return c;
    endfunction

    task automatic add_reset(input logic [2:0] cur);
        cyc_t c;
        c = noise();
        c.rst = 1'b1;
        c.est = cur;
        q.push_back(c);
    endtask

    // kind: 0 alu, 1 load, 2 store, 3 muldiv, 4 illegal
    task automatic add_instr(input int kind, input bit wr, input int ird, input int ivd,
                             input int drd, input int dvd, input int add, input bit rst_mw);
        cyc_t c;
        bit ld, st, md;
        ld = (kind == 1);
        st = (kind == 2);
        md = (kind == 3);
        for (int i = 0; i < ird; i++) begin
            c = noise(); c.ir = 1'b0; c.est = 3'd0; c.eout = O_IREQ; q.push_back(c);
        end
        c = noise(); c.ir = 1'b1; c.est = 3'd0;
        if (ivd == 0) begin
            c.iv = 1'b1; c.eout = O_IREQ | O_IRWE; q.push_back(c);
        end else begin
            c.iv = 1'b0; c.eout = O_IREQ; q.push_back(c);
            for (int j = 1; j <= ivd; j++) begin
                c = noise(); c.iv = (j == ivd); c.est = 3'd5;
                c.eout = (j == ivd) ? O_IRWE : 8'd0; q.push_back(c);
            end
        end
        c = noise(); c.est = 3'd1; q.push_back(c);
        if (kind == 4) begin
            c = noise(); c.ill = 1'b1; c.est = 3'd2; q.push_back(c);
            return;
        end
        if (md) begin
            for (int k = 0; k <= add; k++) begin
                c = decoded(noise(), ld, st, md); c.ad = (k == add); c.est = 3'd2;
                c.eout = (k == 0) ? O_AST : 8'd0; q.push_back(c);
            end
        end else begin
            c = decoded(noise(), ld, st, md); c.est = 3'd2; q.push_back(c);
        end
        if (ld || st) begin
            for (int i = 0; i < drd; i++) begin
                c = decoded(noise(), ld, st, md); c.dr = 1'b0; c.est = 3'd3;
                c.eout = O_DREQ | (st ? O_DWE : 8'd0); q.push_back(c);
            end
            c = decoded(noise(), ld, st, md); c.dr = 1'b1; c.dv = (dvd == 0); c.est = 3'd3;
            c.eout = O_DREQ | (st ? O_DWE : 8'd0); q.push_back(c);
            for (int j = 1; j <= dvd; j++) begin
                if (rst_mw && j == 2) begin
                    add_reset(3'd6);
                    return;
                end
                c = decoded(noise(), ld, st, md); c.dv = (j == dvd); c.est = 3'd6; q.push_back(c);
            end
        end
        c = decoded(noise(), ld, st, md); c.wr = wr; c.est = 3'd4;
        c.eout = (wr ? O_RFWE : 8'd0) | O_PCWE; q.push_back(c);
    endtask

    initial begin
        cyc_t c;
        logic [CNT_W-1:0] exp_cyc, exp_ret;
        int kind;

        // Directed scenarios first, then randomized instruction mix
        add_instr(0, 1'b1, 0, 0, 0, 0, 0, 1'b0);
        add_instr(0, 1'b1, 2, 3, 0, 0, 0, 1'b0);
        add_instr(1, 1'b1, 0, 0, 0, 2, 0, 1'b0);
        add_instr(2, 1'b0, 0, 0, 0, 0, 0, 1'b0);
        add_instr(3, 1'b1, 0, 0, 0, 0, 5, 1'b0);
        add_instr(3, 1'b1, 1, 1, 0, 0, 0, 1'b0);
        add_instr(1, 1'b1, 0, 0, 1, 3, 0, 1'b1);
        add_instr(0, 1'b1, 0, 0, 0, 0, 0, 1'b0);
        add_reset(3'd0);
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 3);
            add_instr(kind, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 5), 1'b0);
        end
        add_instr(4, 1'b1, 1, 1, 0, 0, 0, 1'b0);
        for (int i = 0; i < 100; i++) begin
            c = noise(); c.est = 3'd7; c.eout = O_TRAP; q.push_back(c);
        end
        add_reset(3'd7);
        for (int n = 0; n < 10; n++) add_instr(0, 1'b1, 0, 0, 0, 0, 0, 1'b0);
        c = noise(); c.ir = 1'b0; c.est = 3'd0; c.eout = O_IREQ; q.push_back(c);

        rst = 1'b1; imem_ready = 1'b0; imem_valid = 1'b0; illegal = 1'b0;
        is_load = 1'b0; is_store = 1'b0; is_muldiv = 1'b0; writes_rd = 1'b0;
        alu_done = 1'b0; dmem_ready = 1'b0; dmem_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_val("reset_state", 32'(state), 32'd0);
        check_val("reset_outs", 32'({imem_req, ir_we, alu_start, dmem_req, dmem_we,
                                     rf_we, pc_we, trapped}), 32'd0);
        check_val("reset_cycle_cnt", 32'(cycle_cnt), 32'd0);
        check_val("reset_instret_cnt", 32'(instret_cnt), 32'd0);
        exp_cyc = '0;
        exp_ret = '0;

        foreach (q[i]) begin
            c = q[i];
            @(negedge clk);
            rst = c.rst; imem_ready = c.ir; imem_valid = c.iv; dmem_ready = c.dr;
            dmem_valid = c.dv; alu_done = c.ad; illegal = c.ill; is_load = c.ld;
            is_store = c.st; is_muldiv = c.md; writes_rd = c.wr;
            #1;
            check_val($sformatf("state[%0d]", i), 32'(state), 32'(c.est));
            check_val($sformatf("outs[%0d]", i), 32'({imem_req, ir_we, alu_start, dmem_req,
                                                      dmem_we, rf_we, pc_we, trapped}), 32'(c.eout));
`ifdef CORE_PERF_COUNTER_EN
            check_val($sformatf("cycle_cnt[%0d]", i), 32'(cycle_cnt), 32'(exp_cyc));
            check_val($sformatf("instret_cnt[%0d]", i), 32'(instret_cnt), 32'(exp_ret));
`else
            check_val($sformatf("cycle_cnt_off[%0d]", i), 32'(cycle_cnt), 32'd0);
            check_val($sformatf("instret_cnt_off[%0d]", i), 32'(instret_cnt), 32'd0);
`endif
            if (c.rst) begin
                exp_cyc = '0;
                exp_ret = '0;
            end else begin
                if (c.est != 3'd7) exp_cyc = exp_cyc + 1'b1;
                if (c.est == 3'd4) exp_ret = exp_ret + 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
